i2s_dac_serializer: RTL and testbench
=====================================

Name: i2s_dac_serializer

Overview:
Parametrised stereo audio DAC serializer, the next generation of the WM8731 serializer. It generates MCLK, BCLK and LRCK from a reference clock-enable. It accepts left/right samples through a valid/ready handshake into a small FIFO and shifts each frame out MSB-first in one of four codec formats. It sits between the FM demodulator audio path and the WM8731 pins.

Parameters:
DATA_W, 16, sample width in bits
SLOT_W, 16, BCLK periods per channel slot (>= DATA_W; sample is MSB-aligned and zero-padded in the slot)
MCLK_HALF, 2, en_ref pulses per MCLK half-period (48 MHz / 4 = 12 MHz)
BCLK_HALF, 12, en_ref pulses per BCLK half-period (48 MHz / 24 = 2 MHz)
FIFO_DEPTH, 2, sample-pair FIFO depth (power of two, >= 2)
MUTE_ON_UNDERRUN, 1, 1 = send zeros on underrun, 0 = repeat the last sample pair

Ports:
clk  in  1  system clock (240 MHz)
reset  in  1  asynchronous reset, active-low
en_ref  in  1  reference clock-enable (48 MHz)
en_frame  in  1  frame-start strobe (sample rate, e.g. 32 kHz), one clk wide
mode  in  2  00 left-justified, 01 I2S, 10 DSP-A, 11 DSP-B; latched at en_frame
mono  in  1  1 = right channel := left channel; sampled at push
s_valid  in  1  sample pair valid
s_left  in  DATA_W  left sample
s_right  in  DATA_W  right sample
s_ready  out  1  FIFO not full
mclk  out  1  codec master clock
bclk  out  1  bit clock
dac_lr_ck  out  1  L/R clock
dac_dat  out  1  serial data
underrun  out  1  one-clk pulse: en_frame arrived with an empty FIFO

Behaviour:
- Reset (low, async): mclk, bclk, dac_lr_ck, dac_dat and underrun = 0. FIFO empty, so s_ready = 1. All counters, shift register, last-pair register and latched mode cleared (mode resets to 00). Reset mid-frame aborts the frame immediately.
- MCLK: a free-running counter advances on en_ref; mclk toggles every MCLK_HALF en_ref pulses. en_frame has no effect on MCLK.
- BCLK: a counter 0..BCLK_HALF-1 advances on en_ref; bclk toggles at the terminal count.
  - en_frame forces the counter and bclk to 0, and takes priority over a coincident en_ref.
  - Shift event = terminal count while bclk = 1 (falling edge). Data changes on falling edges; the codec samples on rising edges.
- Frame start (en_frame):
  - Latch mode.
  - FIFO non-empty: pop the head pair into the shift register as {left slot, right slot}. Each slot = sample followed by SLOT_W-DATA_W zeros.
  - FIFO empty: pulse underrun and load zeros, or the last popped pair when MUTE_ON_UNDERRUN = 0.
  - Reset bit index idx to 0.
- idx increments on each shift event and saturates at 2*SLOT_W+1. Delay modes (I2S, DSP-A) prepend one 0 bit. Once the word is exhausted, dac_dat = 0 until the next en_frame.
- dac_lr_ck and data by mode (idx = BCLK period number since frame start):
  - LJ: lrck = 1 for idx 0..SLOT_W-1, else 0; MSB in idx 0.
  - I2S: lrck = 0 for idx 0..SLOT_W-1, 1 for idx SLOT_W..2*SLOT_W-1; MSB in idx 1.
  - DSP-A: lrck = 1 only in idx 0; MSB in idx 1, slots contiguous.
  - DSP-B: lrck = 1 only in idx 0; MSB in idx 0, slots contiguous.
  - After 2*SLOT_W periods, lrck holds its value until the next en_frame.
- FIFO:
  - Push when s_valid && s_ready. Pop only at en_frame.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - No bypass: a push in the same cycle as en_frame on an empty FIFO still produces an underrun, and the pushed pair is sent in the next frame.
  - s_ready = !full (combinational from count).
- Latency: a pushed pair is emitted on the first en_frame at which it is the FIFO head.
- en_frame before the previous word finishes truncates that word (no error flag).

Decomposition:
- Package i2s_pkg: mode_t enum (MODE_LJ, MODE_I2S, MODE_DSPA, MODE_DSPB); helper function for the delay bit per mode.
- Sub-module sample_fifo: parametrised synchronous FIFO of width 2*DATA_W and depth FIFO_DEPTH, with push, pop, full, empty and async active-low reset.

Test Plan:
(Defaults; en_ref every clk unless stated; dac_dat sampled at bclk rising edges.)
1. Reset release with en_ref toggling -> all outputs 0, s_ready = 1; mclk period = 4 en_ref pulses; bclk period = 24 en_ref pulses, both 50 % duty.
2. mode = 00, push L = 0xA5A5 R = 0x3C3C, then en_frame -> lrck high for 16 BCLK periods then low; 32 bits = 0xA5A53C3C, followed by 0s.
3. mode = 01, L = 0x8001 R = 0x7FFE -> first bit 0, next 32 bits = 0x80017FFE; lrck low for periods 0..15, high for 16..31.
4. mode = 11, L = 0x1234 R = 0x5678 -> lrck high only in period 0; bits = 0x12345678 from period 0. mode = 10 with the same data -> same bits shifted by one period.
5. en_frame with an empty FIFO -> underrun high for exactly 1 clk; MUTE_ON_UNDERRUN = 1 gives all-zero data; = 0 repeats the previous pair (0x12345678).
6. Push 2 pairs -> s_ready = 0 and a third s_valid is held; en_frame -> s_ready = 1 next cycle. Assert reset at idx = 10 -> all outputs 0 asynchronously and the FIFO empties. mono = 1 with L = 0x4000 -> bits = 0x40004000.

Source files
------------

// File: rtl/i2s_dac_serializer_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
//
// Shared types and helpers for the stereo DAC serializer.
//   mode_t     : codec frame format, latched at every frame start
//   mode_delay : 1 when the format puts one idle bit before the MSB
// -----------------------------------------------------------------------------
package i2s_pkg;

  typedef enum logic [1:0] {
    MODE_LJ   = 2'b00,  // left-justified: MSB in the first BCLK period
    MODE_I2S  = 2'b01,  // Philips I2S: MSB one BCLK period after LRCK changes
    MODE_DSPA = 2'b10,  // DSP-A: one-period LRCK pulse, MSB in the next period
    MODE_DSPB = 2'b11   // DSP-B: one-period LRCK pulse, MSB in the same period
  } mode_t;

  // Number of idle BCLK periods (0 or 1) ahead of the left MSB.
  function automatic logic mode_delay(input mode_t m);
    return (m == MODE_I2S) || (m == MODE_DSPA);
  endfunction

endpackage

// File: rtl/i2s_dac_serializer_sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
//
// Synchronous FIFO holding left/right sample pairs for the DAC serializer.
// Push and pop in the same cycle are both honoured. Pushes into a full FIFO
// and pops from an empty FIFO are ignored. Read data is the current head,
// available combinationally (show-ahead).
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous reset, active-low; empties the FIFO
//   push     in   write wr_data this cycle
//   wr_data  in   WIDTH-bit entry to store
//   pop      in   discard the head entry this cycle
//   rd_data  out  head entry (undefined content while empty)
//   full     out  DEPTH entries stored
//   empty    out  no entries stored
// -----------------------------------------------------------------------------
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2    // power of two, >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // NOTE: the storage array deliberately has no reset; only the pointers and
  // count need one, and leaving the data RAM unreset keeps it mappable to
  // plain memory cells.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);

endmodule

// File: rtl/i2s_dac_serializer.sv
// -----------------------------------------------------------------------------
// i2s_dac_serializer
//
// Stereo audio DAC serializer for the WM8731. Derives MCLK and BCLK from the
// en_ref clock-enable, buffers left/right sample pairs in a small FIFO, and at
// every en_frame strobe shifts one pair out MSB-first in one of four codec
// formats (left-justified, I2S, DSP-A, DSP-B).
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous reset, active-low; aborts any frame in flight
//   en_ref     in   reference clock-enable that paces MCLK and BCLK
//   en_frame   in   one-clk frame-start strobe at the sample rate
//   mode       in   frame format (mode_t encoding), latched at en_frame
//   mono       in   1: right channel takes the left sample (sampled at push)
//   s_valid    in   sample pair valid
//   s_left     in   left sample
//   s_right    in   right sample
//   s_ready    out  FIFO can accept a pair this cycle
//   mclk       out  codec master clock
//   bclk       out  bit clock; data changes on its falling edge
//   dac_lr_ck  out  left/right framing clock
//   dac_dat    out  serial data
//   underrun   out  one-clk pulse: en_frame found the FIFO empty
// -----------------------------------------------------------------------------
module i2s_dac_serializer
  import i2s_pkg::*;
#(
  parameter int DATA_W           = 16,
  parameter int SLOT_W           = 16,  // BCLK periods per channel, >= DATA_W
  parameter int MCLK_HALF        = 2,   // en_ref pulses per MCLK half-period
  parameter int BCLK_HALF        = 12,  // en_ref pulses per BCLK half-period
  parameter int FIFO_DEPTH       = 2,   // pair FIFO depth, power of two >= 2
  parameter bit MUTE_ON_UNDERRUN = 1'b1 // 1: zeros on underrun, 0: repeat last
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_ref,
  input  logic              en_frame,
  input  logic [1:0]        mode,
  input  logic              mono,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              s_ready,
  output logic              mclk,
  output logic              bclk,
  output logic              dac_lr_ck,
  output logic              dac_dat,
  output logic              underrun
);

  localparam int PAIR_W  = 2 * DATA_W;
  localparam int WORD_W  = 2 * SLOT_W;
  // Bit index runs 0..WORD_W and then parks one past the last delayed bit.
  localparam int IDX_MAX = WORD_W + 1;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam int MCLK_W  = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int BCLK_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  logic [MCLK_W-1:0] r_mclk_cnt;
  logic              r_mclk;
  logic [BCLK_W-1:0] r_bclk_cnt;
  logic              r_bclk;

  mode_t             r_mode;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_shift;
  logic [PAIR_W-1:0] r_last;
  logic              r_lrck;
  logic              r_dac_dat;
  logic              r_underrun;

  mode_t             w_mode_in;
  logic              w_bclk_tc;
  logic              w_shift_evt;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic [PAIR_W-1:0] w_fifo_wr;
  logic [PAIR_W-1:0] w_fifo_rd;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [PAIR_W-1:0] w_load_pair;
  logic [WORD_W-1:0] w_load_word;
  logic              w_delay;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [WORD_W-1:0] w_shift_nxt;

  assign w_mode_in = mode_t'(mode);

  // LRCK level for a given BCLK period of the frame. Past the end of the
  // word these expressions already yield the level of the last period, so
  // LRCK holds without any extra state.
  function automatic logic lrck_for(input mode_t m, input logic [IDX_W-1:0] idx);
    case (m)
      MODE_LJ:  return idx < IDX_W'(SLOT_W);
      MODE_I2S: return idx >= IDX_W'(SLOT_W);
      default:  return idx == '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // MCLK: free-running divider on en_ref, unaffected by en_frame.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mclk_cnt <= '0;
      r_mclk     <= 1'b0;
    end else if (en_ref) begin
      if (r_mclk_cnt == MCLK_W'(MCLK_HALF - 1)) begin
        r_mclk_cnt <= '0;
        r_mclk     <= ~r_mclk;
      end else begin
        r_mclk_cnt <= r_mclk_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BCLK: divider on en_ref, re-phased by en_frame so every frame starts with
  // BCLK low and a full half-period before the first rising edge.
  // ---------------------------------------------------------------------------
  assign w_bclk_tc   = en_ref && (r_bclk_cnt == BCLK_W'(BCLK_HALF - 1));
  // Falling edge of BCLK; suppressed when en_frame re-phases the divider.
  assign w_shift_evt = w_bclk_tc && r_bclk && !en_frame;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bclk_cnt <= '0;
      r_bclk     <= 1'b0;
    end else if (en_frame) begin
      r_bclk_cnt <= '0;
      r_bclk     <= 1'b0;
    end else if (en_ref) begin
      if (w_bclk_tc) begin
        r_bclk_cnt <= '0;
        r_bclk     <= ~r_bclk;
      end else begin
        r_bclk_cnt <= r_bclk_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO. Pops happen only at frame start; there is no bypass, so a
  // pair pushed alongside en_frame into an empty FIFO waits a full frame.
  // ---------------------------------------------------------------------------
  assign s_ready     = !w_fifo_full;
  assign w_fifo_push = s_valid && !w_fifo_full;
  assign w_fifo_pop  = en_frame && !w_fifo_empty;
  assign w_fifo_wr   = {s_left, (mono ? s_left : s_right)};

  sample_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_fifo_push),
    .wr_data (w_fifo_wr),
    .pop     (w_fifo_pop),
    .rd_data (w_fifo_rd),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Frame word selection and slot packing: each sample is MSB-aligned in its
  // slot with zero padding below it.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_load_pair = r_last;
    if (!w_fifo_empty) begin
      w_load_pair = w_fifo_rd;
    end else if (MUTE_ON_UNDERRUN) begin
      w_load_pair = '0;
    end
    w_load_word = '0;
    w_load_word[WORD_W-1 -: DATA_W] = w_load_pair[PAIR_W-1 -: DATA_W];
    w_load_word[SLOT_W-1 -: DATA_W] = w_load_pair[DATA_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Shift path. The shift register only advances once the bit on the wire was
  // a data bit (idx >= delay), so in delay modes the MSB stays put through the
  // leading idle period. Zero fill makes dac_dat fall to 0 after the word.
  // ---------------------------------------------------------------------------
  assign w_delay     = mode_delay(r_mode);
  assign w_idx_nxt   = (r_idx == IDX_W'(IDX_MAX)) ? r_idx : r_idx + 1'b1;
  assign w_shift_nxt = (r_idx >= IDX_W'(w_delay)) ? {r_shift[WORD_W-2:0], 1'b0}
                                                  : r_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode     <= MODE_LJ;
      r_idx      <= '0;
      r_shift    <= '0;
      r_last     <= '0;
      r_lrck     <= 1'b0;
      r_dac_dat  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= en_frame && w_fifo_empty;
      if (en_frame) begin
        // A new frame always wins, truncating whatever word was in flight.
        r_mode    <= w_mode_in;
        r_idx     <= '0;
        r_shift   <= w_load_word;
        r_dac_dat <= mode_delay(w_mode_in) ? 1'b0 : w_load_word[WORD_W-1];
        r_lrck    <= lrck_for(w_mode_in, '0);
        if (!w_fifo_empty) begin
          r_last <= w_fifo_rd;
        end
      end else if (w_shift_evt) begin
        r_idx     <= w_idx_nxt;
        r_shift   <= w_shift_nxt;
        r_dac_dat <= w_shift_nxt[WORD_W-1];
        r_lrck    <= lrck_for(r_mode, w_idx_nxt);
      end
    end
  end

  assign mclk      = r_mclk;
  assign bclk      = r_bclk;
  assign dac_lr_ck = r_lrck;
  assign dac_dat   = r_dac_dat;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// -----------------------------------------------------------------------------
// tb_i2s_dac_serializer
//
// Two serializer instances share all inputs: one mutes on underrun, the other
// repeats the last pair. A queue-based model predicts which pair each frame
// carries; expected bits and LRCK levels per BCLK period are computed from the
// frame-format rules. dac_dat and dac_lr_ck are captured at BCLK rising edges.
// -----------------------------------------------------------------------------
module tb_i2s_dac_serializer;

  localparam int DATA_W     = 16;
  localparam int SLOT_W     = 16;
  localparam int MCLK_HALF  = 2;
  localparam int BCLK_HALF  = 12;
  localparam int FIFO_DEPTH = 2;
  localparam int PAIR_W     = 2 * DATA_W;
  localparam int WORD_W     = 2 * SLOT_W;
  localparam int NPER       = WORD_W + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en_ref = 1'b1;
  logic              en_frame = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic              mono = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_left = '0;
  logic [DATA_W-1:0] s_right = '0;

  logic s_ready_m, mclk_m, bclk_m, lr_m, dat_m, und_m;
  logic s_ready_r, mclk_r, bclk_r, lr_r, dat_r, und_r;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PAIR_W-1:0] model_q[$];
  logic [PAIR_W-1:0] model_last = '0;

  always #5 clk = ~clk;

  i2s_dac_serializer #(
    .DATA_W(DATA_W), .SLOT_W(SLOT_W), .MCLK_HALF(MCLK_HALF),
    .BCLK_HALF(BCLK_HALF), .FIFO_DEPTH(FIFO_DEPTH), .MUTE_ON_UNDERRUN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .en_ref(en_ref), .en_frame(en_frame),
    .mode(mode), .mono(mono), .s_valid(s_valid), .s_left(s_left),
    .s_right(s_right), .s_ready(s_ready_m), .mclk(mclk_m), .bclk(bclk_m),
    .dac_lr_ck(lr_m), .dac_dat(dat_m), .underrun(und_m)
  );

  i2s_dac_serializer #(
    .DATA_W(DATA_W), .SLOT_W(SLOT_W), .MCLK_HALF(MCLK_HALF),
    .BCLK_HALF(BCLK_HALF), .FIFO_DEPTH(FIFO_DEPTH), .MUTE_ON_UNDERRUN(1'b0)
  ) dut_rep (
    .clk(clk), .reset(reset), .en_ref(en_ref), .en_frame(en_frame),
    .mode(mode), .mono(mono), .s_valid(s_valid), .s_left(s_left),
    .s_right(s_right), .s_ready(s_ready_r), .mclk(mclk_r), .bclk(bclk_r),
    .dac_lr_ck(lr_r), .dac_dat(dat_r), .underrun(und_r)
  );

  // ---------------------------------------------------------------------------
  // Reference rules
  // ---------------------------------------------------------------------------
  function automatic logic [WORD_W-1:0] to_word(input logic [PAIR_W-1:0] pair);
    logic [WORD_W-1:0] w;
    w = '0;
    w[WORD_W-1 -: DATA_W] = pair[PAIR_W-1 -: DATA_W];
    w[SLOT_W-1 -: DATA_W] = pair[DATA_W-1:0];
    return w;
  endfunction

  function automatic logic exp_bit(input logic [WORD_W-1:0] w, input int m, input int p);
    int k;
    k = p - (((m == 1) || (m == 2)) ? 1 : 0);
    if (k >= 0 && k < WORD_W) return w[WORD_W-1-k];
    return 1'b0;
  endfunction

  function automatic logic exp_lrck(input int m, input int p);
    int q;
    q = (p < WORD_W) ? p : WORD_W - 1;
    case (m)
      0:       return q < SLOT_W;
      1:       return q >= SLOT_W;
      default: return q == 0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                           input logic mn);
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = (model_q.size() < FIFO_DEPTH);
    n_checks++;
    if (s_ready_m !== exp_rdy || s_ready_r !== exp_rdy) begin
      n_fail++;
      $display("FAIL push_ready: got %b/%b, expected %b", s_ready_m, s_ready_r, exp_rdy);
    end
    if (s_ready_m === 1'b1) begin
      s_valid = 1'b1; s_left = l; s_right = r; mono = mn;
      model_q.push_back({l, (mn ? l : r)});
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [1:0] m, input bit push_too,
                             input logic [DATA_W-1:0] pl, input logic [DATA_W-1:0] pr,
                             input logic pmono,
                             output logic [PAIR_W-1:0] pair_m, output logic [PAIR_W-1:0] pair_r);
    logic exp_und;
    @(negedge clk);
    mode = m; en_frame = 1'b1;
    if (push_too) begin
      s_valid = 1'b1; s_left = pl; s_right = pr; mono = pmono;
    end
    exp_und = (model_q.size() == 0);
    if (exp_und) begin
      pair_m = '0;
      pair_r = model_last;
    end else begin
      pair_m = model_q.pop_front();
      pair_r = pair_m;
      model_last = pair_m;
    end
    if (push_too) model_q.push_back({pl, (pmono ? pl : pr)});
    @(negedge clk);
    en_frame = 1'b0;
    if (push_too) s_valid = 1'b0;
    n_checks++;
    if (und_m !== exp_und || und_r !== exp_und) begin
      n_fail++;
      $display("FAIL underrun_pulse: got %b/%b, expected %b", und_m, und_r, exp_und);
    end
  endtask

  task automatic check_frame(input logic [1:0] m, input int n,
                             input logic [PAIR_W-1:0] pair_m, input logic [PAIR_W-1:0] pair_r,
                             input string tag);
    logic [NPER-1:0]   got_m, got_r, got_lr, exp_m, exp_r, exp_lr;
    logic [WORD_W-1:0] w_m, w_r;
    logic              prev;
    int                got, cyc, budget;
    got_m = '0; got_r = '0; got_lr = '0; exp_m = '0; exp_r = '0; exp_lr = '0;
    w_m = to_word(pair_m);
    w_r = to_word(pair_r);
    got = 0; cyc = 0;
    budget = (n + 1) * 2 * BCLK_HALF + 16;
    @(negedge clk);
    n_checks++;
    if (und_m !== 1'b0 || und_r !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_width %s: got %b/%b one clk later, expected 0", tag, und_m, und_r);
    end
    prev = bclk_m;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bclk_m === 1'b1 && prev === 1'b0) begin
        got_m[got] = dat_m; got_r[got] = dat_r; got_lr[got] = lr_m;
        got++;
      end
      prev = bclk_m;
    end
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL bclk_timeout %s: saw %0d rising edges, expected %0d", tag, got, n);
    end
    for (int p = 0; p < n; p++) begin
      exp_m[p]  = exp_bit(w_m, int'(m), p);
      exp_r[p]  = exp_bit(w_r, int'(m), p);
      exp_lr[p] = exp_lrck(int'(m), p);
    end
    n_checks++;
    if (got_m !== exp_m) begin
      n_fail++;
      $display("FAIL data_mute %s: got %h, expected %h (bit p = period p)", tag, got_m, exp_m);
    end
    n_checks++;
    if (got_r !== exp_r) begin
      n_fail++;
      $display("FAIL data_repeat %s: got %h, expected %h (bit p = period p)", tag, got_r, exp_r);
    end
    n_checks++;
    if (got_lr !== exp_lr) begin
      n_fail++;
      $display("FAIL lrck %s: got %h, expected %h (bit p = period p)", tag, got_lr, exp_lr);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({mclk_m, bclk_m, lr_m, dat_m, und_m, mclk_r, bclk_r, lr_r, dat_r, und_r} !== 10'b0 ||
        s_ready_m !== 1'b1 || s_ready_r !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: outputs %b%b%b%b%b ready %b%b, expected 00000 ready 11",
               mclk_m, bclk_m, lr_m, dat_m, und_m, s_ready_m, s_ready_r);
    end
    reset = 1'b1;
  endtask

  // Random en_ref gaps: each clock half-period must span exactly HALF pulses.
  task automatic test_clocks();
    int   cm, cb, tm, tb;
    bit   er, dat_seen;
    logic pm, pb;
    cm = 0; cb = 0; tm = 0; tb = 0; dat_seen = 0;
    er = en_ref; pm = mclk_m; pb = bclk_m;
    for (int i = 0; i < 480; i++) begin
      @(negedge clk);
      if (er) begin cm++; cb++; end
      if (mclk_m !== pm) begin
        tm++;
        n_checks++;
        if (cm != MCLK_HALF) begin
          n_fail++;
          $display("FAIL mclk_half: %0d en_ref pulses, expected %0d", cm, MCLK_HALF);
        end
        cm = 0;
      end
      if (bclk_m !== pb) begin
        tb++;
        n_checks++;
        if (cb != BCLK_HALF) begin
          n_fail++;
          $display("FAIL bclk_half: %0d en_ref pulses, expected %0d", cb, BCLK_HALF);
        end
        cb = 0;
      end
      if (dat_m !== 1'b0 || dat_r !== 1'b0) dat_seen = 1;
      pm = mclk_m; pb = bclk_m;
      er = ($urandom_range(0, 3) != 0);
      en_ref = er;
    end
    en_ref = 1'b1;
    n_checks++;
    if (tm < 40 || tb < 8) begin
      n_fail++;
      $display("FAIL clock_toggles: mclk %0d bclk %0d, expected >= 40 and >= 8", tm, tb);
    end
    n_checks++;
    if (dat_seen) begin
      n_fail++;
      $display("FAIL idle_data: dac_dat went high before any frame, expected 0");
    end
  endtask

  task automatic test_lj();
    logic [PAIR_W-1:0] pm, pr;
    push_pair(16'hA5A5, 16'h3C3C, 1'b0);
    start_frame(2'b00, 0, '0, '0, 1'b0, pm, pr);
    check_frame(2'b00, NPER, pm, pr, "lj");
  endtask

  task automatic test_i2s();
    logic [PAIR_W-1:0] pm, pr;
    push_pair(16'h8001, 16'h7FFE, 1'b0);
    start_frame(2'b01, 0, '0, '0, 1'b0, pm, pr);
    check_frame(2'b01, NPER, pm, pr, "i2s");
  endtask

  task automatic test_dsp();
    logic [PAIR_W-1:0] pm, pr;
    push_pair(16'h1234, 16'h5678, 1'b0);
    start_frame(2'b11, 0, '0, '0, 1'b0, pm, pr);
    check_frame(2'b11, NPER, pm, pr, "dsp_b");
    push_pair(16'h1234, 16'h5678, 1'b0);
    start_frame(2'b10, 0, '0, '0, 1'b0, pm, pr);
    check_frame(2'b10, NPER, pm, pr, "dsp_a");
  endtask

  task automatic test_underrun();
    logic [PAIR_W-1:0] pm, pr;
    start_frame(2'b00, 0, '0, '0, 1'b0, pm, pr);
    check_frame(2'b00, NPER, pm, pr, "underrun");
    // Push coincident with en_frame on an empty FIFO: still an underrun.
    start_frame(2'b01, 1, 16'hBEEF, 16'h0123, 1'b0, pm, pr);
    check_frame(2'b01, NPER, pm, pr, "underrun_push");
    start_frame(2'b00, 0, '0, '0, 1'b0, pm, pr);
    check_frame(2'b00, NPER, pm, pr, "after_underrun");
  endtask

  task automatic test_full_and_reset();
    logic [PAIR_W-1:0] pm, pr;
    int cyc;
    push_pair(16'hFFFF, 16'h0F0F, 1'b0);
    push_pair(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_left = 16'h3333; s_right = 16'h4444; mono = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (s_ready_m !== 1'b0 || s_ready_r !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b/%b, expected 0", s_ready_m, s_ready_r);
    end
    start_frame(2'b00, 0, '0, '0, 1'b0, pm, pr);
    n_checks++;
    if (s_ready_m !== 1'b1 || s_ready_r !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_pop: got %b/%b, expected 1", s_ready_m, s_ready_r);
    end
    @(negedge clk);
    model_q.push_back({16'h3333, 16'h4444});
    s_valid = 1'b0;
    n_checks++;
    if (s_ready_m !== 1'b0 || s_ready_r !== 1'b0) begin
      n_fail++;
      $display("FAIL held_push: s_ready %b/%b, expected 0", s_ready_m, s_ready_r);
    end
    check_frame(2'b00, 10, pm, pr, "pre_reset");
    cyc = 0;
    while (bclk_m !== 1'b0 && cyc < 2 * BCLK_HALF + 4) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (dat_m !== 1'b1 || lr_m !== 1'b1 || dat_r !== 1'b1 || bclk_m !== 1'b0) begin
      n_fail++;
      $display("FAIL idx10_state: dat %b/%b lrck %b bclk %b, expected 1/1 1 0",
               dat_m, dat_r, lr_m, bclk_m);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mclk_m, bclk_m, lr_m, dat_m, und_m, mclk_r, bclk_r, lr_r, dat_r, und_r} !== 10'b0 ||
        s_ready_m !== 1'b1 || s_ready_r !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: outputs %b%b%b%b%b ready %b%b, expected 00000 ready 11",
               mclk_m, bclk_m, lr_m, dat_m, und_m, s_ready_m, s_ready_r);
    end
    model_q.delete();
    model_last = '0;
    @(negedge clk);
    reset = 1'b1;
    start_frame(2'b00, 0, '0, '0, 1'b0, pm, pr);
    check_frame(2'b00, NPER, pm, pr, "after_reset");
    push_pair(16'h4000, 16'($urandom), 1'b1);
    start_frame(2'b00, 0, '0, '0, 1'b0, pm, pr);
    check_frame(2'b00, NPER, pm, pr, "mono");
  endtask

  task automatic test_back_to_back();
    logic [PAIR_W-1:0] pm, pr;
    logic [1:0] m;
    push_pair(16'($urandom), 16'($urandom), 1'b0);
    push_pair(16'($urandom), 16'($urandom), 1'b0);
    m = 2'($urandom_range(0, 3));
    start_frame(m, 0, '0, '0, 1'b0, pm, pr);
    check_frame(m, 12, pm, pr, "truncated");
    m = 2'($urandom_range(0, 3));
    start_frame(m, 0, '0, '0, 1'b0, pm, pr);
    check_frame(m, NPER, pm, pr, "after_truncate");
  endtask

  task automatic test_random();
    logic [PAIR_W-1:0] pm, pr;
    logic [1:0] m;
    int npush, nper;
    for (int it = 0; it < 10; it++) begin
      npush = $urandom_range(0, FIFO_DEPTH - model_q.size());
      for (int k = 0; k < npush; k++) begin
        push_pair(16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0));
      end
      m = 2'($urandom_range(0, 3));
      nper = ($urandom_range(0, 3) == 0) ? $urandom_range(4, WORD_W) : NPER;
      start_frame(m, 0, '0, '0, 1'b0, pm, pr);
      check_frame(m, nper, pm, pr, "random");
    end
  endtask

  initial begin
    test_reset();
    test_clocks();
    test_lj();
    test_i2s();
    test_dsp();
    test_underrun();
    test_full_and_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
